// File: rtl/slot_i2s_tx_pkg.sv
// Shared definitions for the slot I2S transmitter.
//   I2S_FRAME_BITS / I2S_HALF_BITS : bck periods per frame / per channel half
//   I2S_IDX_W                      : width of the frame bit index
//   i2s_tx_state_t                 : transmitter states IDLE, RUN, STOP
//   SlotMode                       : slot mode; only DAC2 and DAC8 transmit
package slot_i2s_tx_pkg;

    localparam int unsigned I2S_FRAME_BITS = 64;
    localparam int unsigned I2S_HALF_BITS  = 32;
    localparam int unsigned I2S_IDX_W      = $clog2(I2S_FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } i2s_tx_state_t;

    typedef enum logic [1:0] {
        ADC2,
        ADC8,
        DAC2,
        DAC8
    } SlotMode;

    function automatic logic is_dac(input SlotMode m);
        return (m == DAC2) || (m == DAC8);
    endfunction

endpackage

// File: rtl/slot_i2s_tx_clkgen.sv
// Bit clock and frame timing generator for slot_i2s_tx.
// Ports:
//   mclk, reset_n : clock, asynchronous active-low reset
//   run           : high while the transmitter is active; low holds everything cleared
//   bck           : bit clock, BCK_HALF mclk per half-period, starts low
//   lrck          : 0 for bit index 0..31, 1 for 32..63; updated on bck falling edges
//   bit_idx       : current frame bit index 0..63
//   bck_fall      : strobe, high in the cycle whose edge drives bck low
//   frame_end     : strobe, bck_fall on the last bit (index wraps to 0)
module slot_i2s_clkgen
    import slot_i2s_tx_pkg::*;
#(
    parameter int unsigned BCK_HALF = 2
) (
    input  logic                 mclk,
    input  logic                 reset_n,
    input  logic                 run,
    output logic                 bck,
    output logic                 lrck,
    output logic [I2S_IDX_W-1:0] bit_idx,
    output logic                 bck_fall,
    output logic                 frame_end
);

    localparam int unsigned DIV_W = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;

    logic [DIV_W-1:0]     div;
    logic                 tick;
    logic [I2S_IDX_W-1:0] next_idx;

    always_comb begin
        tick      = run && (div == DIV_W'(BCK_HALF - 1));
        bck_fall  = tick && bck;
        frame_end = bck_fall && (bit_idx == I2S_IDX_W'(I2S_FRAME_BITS - 1));
        next_idx  = bit_idx + I2S_IDX_W'(1);
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            div     <= '0;
            bck     <= 1'b0;
            lrck    <= 1'b0;
            bit_idx <= '0;
        end else if (!run) begin
            div     <= '0;
            bck     <= 1'b0;
            lrck    <= 1'b0;
            bit_idx <= '0;
        end else if (tick) begin
            div <= '0;
            bck <= ~bck;
            if (bck) begin
                // index wraps 63->0 by natural overflow of the 6-bit counter
                bit_idx <= next_idx;
                lrck    <= (next_idx >= I2S_IDX_W'(I2S_HALF_BITS));
            end
        end else begin
            div <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/slot_i2s_tx.sv
// Slot I2S transmitter: accepts 8-channel frames into a one-frame holding
// register and serialises them as I2S on up to four data lines.
// Ports:
//   mclk, reset_n      : sole clock, asynchronous active-low reset
//   enable, mode       : run request and slot mode (DAC2 / DAC8 transmit)
//   in_data            : 8 samples, channel c at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   in_valid, in_ready : frame handshake into the holding register
//   bck, lrck, sdata   : I2S lines (sdata[n] carries channels 2n / 2n+1)
//   oe                 : slot drive enable, high in RUN and STOP
//   underrun           : one-cycle pulse when a frame load finds no held frame
//   underrun_count     : saturating underrun counter
// Build option: define SLOT_I2S_UNDERRUN_COUNT_EN to include the underrun
// counter; otherwise underrun_count is tied to zero.
module slot_i2s_tx
    import slot_i2s_tx_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned BCK_HALF     = 2
) (
    input  logic                      mclk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  SlotMode                   mode,
    input  logic [8*SAMPLE_WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      bck,
    output logic                      lrck,
    output logic [3:0]                sdata,
    output logic                      oe,
    output logic                      underrun,
    output logic [15:0]               underrun_count
);

    i2s_tx_state_t state, state_n;

    logic                      hold_full, hold_full_n;
    logic [8*SAMPLE_WIDTH-1:0] hold;
    logic [3:0][SAMPLE_WIDTH-1:0] sh_l, sh_r;

    logic                 start, load, xfer, run;
    logic [I2S_IDX_W-1:0] bit_idx, next_idx;
    logic                 bck_fall, frame_end;

    slot_i2s_clkgen #(
        .BCK_HALF(BCK_HALF)
    ) u_clkgen (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .run       (run),
        .bck       (bck),
        .lrck      (lrck),
        .bit_idx   (bit_idx),
        .bck_fall  (bck_fall),
        .frame_end (frame_end)
    );

    always_comb begin
        start    = enable && is_dac(mode);
        xfer     = in_valid && in_ready;
        run      = (state != IDLE);
        next_idx = bit_idx + I2S_IDX_W'(1);
        load     = 1'b0;
        state_n  = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    load    = 1'b1;
                end
            end
            default: begin
                // RUN and STOP share one rule: the start condition decides
                // whether the frame boundary reloads or returns to IDLE.
                if (frame_end) begin
                    state_n = start ? RUN : IDLE;
                    load    = start;
                end else begin
                    state_n = start ? RUN : STOP;
                end
            end
        endcase
        hold_full_n = hold_full;
        if (load) hold_full_n = 1'b0;
        if (xfer) hold_full_n = 1'b1;
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            hold      <= '0;
            in_ready  <= 1'b0;
            sh_l      <= '0;
            sh_r      <= '0;
            sdata     <= '0;
            oe        <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_n;
            hold_full <= hold_full_n;
            in_ready  <= !hold_full_n;
            oe        <= (state_n != IDLE);
            underrun  <= load && !hold_full;
            if (xfer) hold <= in_data;

            if (load) begin
                // A load coincides with index 0, which always drives 0.
                sdata <= '0;
                for (int unsigned n = 0; n < 4; n++) begin
                    if (hold_full && (n == 0 || mode == DAC8)) begin
                        sh_l[n] <= hold[(2*n)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                        sh_r[n] <= hold[(2*n+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                    end else begin
                        sh_l[n] <= '0;
                        sh_r[n] <= '0;
                    end
                end
            end else if (bck_fall) begin
                if (next_idx[I2S_IDX_W-2:0] == '0) begin
                    sdata <= '0;
                end else begin
                    // Shift registers fill with zeros, so bits past the LSB drive 0.
                    for (int unsigned n = 0; n < 4; n++) begin
                        if (next_idx[I2S_IDX_W-1]) begin
                            sdata[n] <= sh_r[n][SAMPLE_WIDTH-1];
                            sh_r[n]  <= sh_r[n] << 1;
                        end else begin
                            sdata[n] <= sh_l[n][SAMPLE_WIDTH-1];
                            sh_l[n]  <= sh_l[n] << 1;
                        end
                    end
                end
            end
        end
    end

`ifdef SLOT_I2S_UNDERRUN_COUNT_EN
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_count <= '0;
        end else if (load && !hold_full && (underrun_count != '1)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`else
    assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_slot_i2s_tx.sv
// Self-checking bench for slot_i2s_tx: an I2S receiver reconstructs frames
// from the serial lines and compares them with frames predicted from the
// samples and mode the bench supplied.
module tb_slot_i2s_tx;
    import slot_i2s_tx_pkg::*;

    localparam int unsigned SW         = 24;
    localparam int unsigned BH         = 2;
    localparam int unsigned FRAME_MCLK = 2 * 64 * BH;

    typedef logic [8*SW-1:0] fin_t;
    typedef struct packed {
        logic [3:0][SW-1:0] l;
        logic [3:0][SW-1:0] r;
    } frame_t;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic        enable;
    SlotMode     mode;
    fin_t        in_data;
    logic        in_valid;
    logic        in_ready;
    logic        bck;
    logic        lrck;
    logic [3:0]  sdata;
    logic        oe;
    logic        underrun;
    logic [15:0] underrun_count;

    slot_i2s_tx #(
        .SAMPLE_WIDTH(SW),
        .BCK_HALF    (BH)
    ) dut (
        .mclk           (mclk),
        .reset_n        (reset_n),
        .enable         (enable),
        .mode           (mode),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .bck            (bck),
        .lrck           (lrck),
        .sdata          (sdata),
        .oe             (oe),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 mclk = ~mclk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- receiver / monitor ----------------
    int     cyc       = 0;
    int     rx_pos    = 0;
    int     fmt_err   = 0;
    int     ur_pulses = 0;
    logic   bck_q     = 1'b0;
    logic   lrck_q    = 1'b0;
    frame_t cur       = '0;
    frame_t rx_q [$];
    frame_t exp_q[$];
    int     lr_rise[$];

    always @(negedge mclk) begin
        int half;
        int k;
        cyc++;
        if (underrun === 1'b1) ur_pulses++;
        if (oe !== 1'b1) begin
            rx_pos = 0;
            cur    = '0;
        end else if (bck === 1'b1 && bck_q === 1'b0) begin
            half = rx_pos / 32;
            k    = rx_pos % 32;
            if (lrck !== (rx_pos >= 32)) fmt_err++;
            for (int n = 0; n < 4; n++) begin
                if (k >= 1 && k <= SW) begin
                    if (half == 1) cur.r[n][SW-k] = sdata[n];
                    else           cur.l[n][SW-k] = sdata[n];
                end else if (sdata[n] !== 1'b0) begin
                    fmt_err++;
                end
            end
            rx_pos++;
            if (rx_pos == 64) begin
                rx_q.push_back(cur);
                cur    = '0;
                rx_pos = 0;
            end
        end
        if (lrck === 1'b1 && lrck_q === 1'b0) lr_rise.push_back(cyc);
        bck_q  = bck;
        lrck_q = lrck;
    end

    // ---------------- reference model ----------------
    function automatic frame_t model(input fin_t f, input logic dac8);
        frame_t m;
        m = '0;
        for (int n = 0; n < 4; n++) begin
            if (n == 0 || dac8) begin
                m.l[n] = f[(2*n)*SW +: SW];
                m.r[n] = f[(2*n+1)*SW +: SW];
            end
        end
        return m;
    endfunction

    function automatic fin_t rand_frame();
        fin_t f;
        for (int c = 0; c < 8; c++) f[c*SW +: SW] = SW'($urandom);
        return f;
    endfunction

    task automatic compare_frames(input string tag);
        int ncmp;
        chk({tag, "_nframes"}, rx_q.size(), exp_q.size());
        chk({tag, "_format"}, fmt_err, 0);
        ncmp = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < ncmp; i++) begin
            for (int n = 0; n < 4; n++) begin
                chk($sformatf("%s_f%0d_line%0d_L", tag, i, n), rx_q[i].l[n], exp_q[i].l[n]);
                chk($sformatf("%s_f%0d_line%0d_R", tag, i, n), rx_q[i].r[n], exp_q[i].r[n]);
            end
        end
        rx_q.delete();
        exp_q.delete();
        fmt_err = 0;
    endtask

    // ---------------- stimulus helpers (all aligned to negedge) ----------------
    task automatic do_reset(input string tag);
        @(negedge mclk);
        reset_n  = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        mode     = ADC2;
        #1 chk({tag, "_rst_outputs"},
               {bck, lrck, sdata, oe, underrun, in_ready, underrun_count}, '0);
        repeat (3) @(negedge mclk);
        reset_n = 1'b1;
        #1 chk({tag, "_rst_ready_low"}, in_ready, 0);
        @(negedge mclk);
        chk({tag, "_rst_ready_rise"}, in_ready, 1);
        rx_q.delete();
        exp_q.delete();
        lr_rise.delete();
        ur_pulses = 0;
        fmt_err   = 0;
    endtask

    task automatic send_frame(input fin_t f, input string tag);
        in_data  = f;
        in_valid = 1'b1;
        for (int t = 0; t < 4 * FRAME_MCLK; t++) begin
            if (in_ready === 1'b1) begin
                @(negedge mclk);
                in_valid = 1'b0;
                return;
            end
            @(negedge mclk);
        end
        in_valid = 1'b0;
        chk({tag, "_send_timeout"}, in_ready, 1);
    endtask

    task automatic wait_ready(input string tag);
        for (int t = 0; t < 4 * FRAME_MCLK; t++) begin
            if (in_ready === 1'b1) return;
            @(negedge mclk);
        end
        chk({tag, "_ready_timeout"}, in_ready, 1);
    endtask

    task automatic wait_pos(input int n, input string tag);
        for (int t = 0; t < 4 * FRAME_MCLK; t++) begin
            if (rx_pos >= n) return;
            @(negedge mclk);
        end
        chk({tag, "_pos_timeout"}, rx_pos, n);
    endtask

    task automatic wait_underrun(input int n, input string tag);
        for (int t = 0; t < 4 * FRAME_MCLK; t++) begin
            if (ur_pulses >= n) return;
            @(negedge mclk);
        end
        chk({tag, "_underrun_timeout"}, ur_pulses, n);
    endtask

    task automatic wait_oe_low(input string tag);
        for (int t = 0; t < 4 * FRAME_MCLK; t++) begin
            if (oe === 1'b0) return;
            @(negedge mclk);
        end
        chk({tag, "_oe_timeout"}, oe, 0);
    endtask

    task automatic check_idle_lines(input string tag);
        chk({tag, "_idle_lines"}, {oe, bck, lrck, sdata}, '0);
    endtask

    // ---------------- scenarios ----------------
    fin_t    fa, fb [4], fc1, fc3, ff1, ff2, fg [4];
    SlotMode mg [4];

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        mode     = ADC2;
        in_data  = '0;
        in_valid = 1'b0;

        // A: single DAC2 frame, graceful stop at bit 10
        do_reset("a");
        fa = rand_frame();
        fa[0 +: SW]  = 24'hA5A5A5;
        fa[SW +: SW] = 24'h123456;
        send_frame(fa, "a");
        exp_q.push_back(model(fa, 1'b0));
        mode   = DAC2;
        enable = 1'b1;
        wait_pos(10, "a");
        enable = 1'b0;
        repeat (2) @(negedge mclk);
        chk("a_oe_in_stop", oe, 1);
        wait_oe_low("a");
        chk("a_boundary_pos", rx_pos, 0);
        chk("a_frames_at_oe_fall", rx_q.size(), 1);
        compare_frames("a");
        check_idle_lines("a");
        chk("a_underruns", ur_pulses, 0);
        repeat (20) @(negedge mclk);
        check_idle_lines("a_later");

        // B: DAC8 continuous, 4 frames, channel c = {frame, c}
        do_reset("b");
        for (int fr = 0; fr < 4; fr++)
            for (int c = 0; c < 8; c++)
                fb[fr][c*SW +: SW] = SW'({8'(fr), 8'(c)});
        send_frame(fb[0], "b");
        exp_q.push_back(model(fb[0], 1'b1));
        mode   = DAC8;
        enable = 1'b1;
        for (int fr = 1; fr < 4; fr++) begin
            wait_ready("b");
            send_frame(fb[fr], "b");
            exp_q.push_back(model(fb[fr], 1'b1));
        end
        wait_ready("b_last");
        wait_pos(8, "b");
        enable = 1'b0;
        wait_oe_low("b");
        compare_frames("b");
        chk("b_underruns", ur_pulses, 0);
        chk("b_lrck_rises", lr_rise.size(), 4);
        for (int i = 1; i < lr_rise.size(); i++)
            chk($sformatf("b_lrck_period%0d", i), lr_rise[i] - lr_rise[i-1], FRAME_MCLK);

        // C: underrun on frame 2 of 3
        do_reset("c");
        fc1 = rand_frame();
        fc3 = rand_frame();
        send_frame(fc1, "c");
        exp_q.push_back(model(fc1, 1'b1));
        exp_q.push_back(model('0, 1'b1));
        exp_q.push_back(model(fc3, 1'b1));
        mode   = DAC8;
        enable = 1'b1;
        wait_ready("c");
        wait_underrun(1, "c");
        send_frame(fc3, "c");
        wait_ready("c_f3");
        wait_pos(5, "c");
        enable = 1'b0;
        wait_oe_low("c");
        compare_frames("c");
        chk("c_underruns", ur_pulses, 1);
`ifdef SLOT_I2S_UNDERRUN_COUNT_EN
        chk("c_underrun_count", underrun_count, 1);
`else
        chk("c_underrun_count", underrun_count, 0);
`endif

        // E: reset mid-frame with a held frame; no stale data afterwards
        do_reset("e0");
        ff1 = rand_frame();
        ff2 = rand_frame();
        send_frame(ff1, "e");
        mode   = DAC8;
        enable = 1'b1;
        wait_ready("e");
        send_frame(ff2, "e");
        wait_pos(40, "e");
        do_reset("e_mid");
        mode   = DAC8;
        enable = 1'b1;
        exp_q.push_back(model('0, 1'b1));
        wait_pos(10, "e_after");
        enable = 1'b0;
        wait_oe_low("e");
        compare_frames("e");
        chk("e_underruns", ur_pulses, 1);
`ifdef SLOT_I2S_UNDERRUN_COUNT_EN
        chk("e_underrun_count", underrun_count, 1);
`else
        chk("e_underrun_count", underrun_count, 0);
`endif

        // F: DAC8 -> ADC2 mid-frame; frame finishes, then IDLE
        do_reset("f");
        ff1 = rand_frame();
        send_frame(ff1, "f");
        exp_q.push_back(model(ff1, 1'b1));
        mode   = DAC8;
        enable = 1'b1;
        wait_ready("f");
        send_frame(rand_frame(), "f");
        wait_pos(20, "f");
        mode = ADC2;
        repeat (2) @(negedge mclk);
        chk("f_oe_in_stop", oe, 1);
        wait_oe_low("f");
        compare_frames("f");
        check_idle_lines("f");
        repeat (FRAME_MCLK + 20) @(negedge mclk);
        check_idle_lines("f_later");
        chk("f_no_more_frames", rx_q.size(), 0);
        chk("f_underruns", ur_pulses, 0);
        enable = 1'b0;

        // G: random data with random DAC2/DAC8 changes mid-frame
        do_reset("g");
        for (int i = 0; i < 4; i++) begin
            fg[i] = rand_frame();
            mg[i] = ($urandom_range(0, 1) == 1) ? DAC8 : DAC2;
            exp_q.push_back(model(fg[i], mg[i] == DAC8));
        end
        send_frame(fg[0], "g");
        mode   = mg[0];
        enable = 1'b1;
        for (int i = 1; i < 4; i++) begin
            wait_ready("g");
            send_frame(fg[i], "g");
            wait_pos($urandom_range(5, 50), "g");
            mode = mg[i];
        end
        wait_ready("g_last");
        wait_pos($urandom_range(5, 50), "g");
        enable = 1'b0;
        wait_oe_low("g");
        compare_frames("g");
        chk("g_underruns", ur_pulses, 0);
        check_idle_lines("g");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/slot_i2s_tx.md
SLOT_I2S_TX -- requirements
Module: slot_i2s_tx

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 24: bits per audio sample, legal range 16..31.
REQ-002 Parameter BCK_HALF, default 2: mclk cycles per bck half-period, minimum 1.
REQ-003 Port mclk, input, 1: sole clock.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port enable, input, 1: run request.
REQ-006 Port mode, input, SlotMode: slot mode; only DAC2 and DAC8 transmit.
REQ-007 Port in_data, input, 8*SAMPLE_WIDTH: frame of 8 samples; channel c is at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-008 Port in_valid, input, 1, and port in_ready, output, 1: frame handshake; a transfer occurs when both are high on an mclk edge.
REQ-009 Port bck, output, 1; port lrck, output, 1; port sdata, output, 4: I2S lines driven to slotdata[0], slotdata[1] and slotdata[5:2].
REQ-010 Port oe, output, 1: slot drive enable, high in RUN and STOP.
REQ-011 Port underrun, output, 1: one-cycle pulse per underrun frame.
REQ-012 Port underrun_count, output, 16: underrun count.

Function
REQ-013 The block SHALL hold a one-frame register: in_ready = !hold_full; a handshake sets hold_full.
REQ-014 States SHALL be IDLE, RUN and STOP:
  - IDLE->RUN when enable is high and mode is DAC2 or DAC8.
  - RUN->STOP when enable goes low or mode becomes ADC2 or ADC8.
  - STOP->RUN if the start condition returns before the frame ends.
  - STOP->IDLE at the frame boundary.
REQ-015 In IDLE: bck=0, lrck=0, sdata=0, divider=0, bit index=0.
REQ-016 bck SHALL toggle every BCK_HALF mclk cycles, starting low; one frame = 64 bck periods = 128*BCK_HALF mclk.
REQ-017 Bit index 0..63 SHALL advance on each bck falling edge and wrap 63->0 at the frame boundary.
REQ-018 lrck SHALL be 0 for index 0..31 (left) and 1 for index 32..63 (right); lrck and sdata change only on bck falling edges.
REQ-019 Frame load:
  - Occurs at the boundary and on the first RUN cycle.
  - If hold_full was set before that cycle: shift registers load from hold, and hold_full clears.
  - Otherwise: all-zero samples load, underrun pulses, and a frame accepted in that same cycle is used at the next boundary (no bypass).
REQ-020 Within each half, at index k (0..31 relative): k=0 drives 0; k=1..SAMPLE_WIDTH drives MSB..LSB; later k drive 0.
REQ-021 Line n SHALL carry channel 2n on the left half and channel 2n+1 on the right half.
REQ-022 DAC2 SHALL transmit line 0 only: sdata[3:1]=0, channels 2..7 discarded.
REQ-023 mode SHALL be sampled only at frame load; a mid-frame change takes effect at the next boundary.
REQ-024 underrun_count SHALL increment per underrun and saturate at 16'hFFFF.
REQ-025 Outputs SHALL be registered; sdata is valid in the same mclk cycle as the bck falling edge.

Reset
REQ-026 While reset_n=0, regardless of state or mid-frame position:
  - state=IDLE, hold_full=0, counters=0.
  - All outputs 0, including in_ready, which rises the first cycle after release.

Configuration
REQ-027 With SLOT_I2S_UNDERRUN_COUNT_EN defined, underrun_count SHALL operate per REQ-024.
REQ-028 Without SLOT_I2S_UNDERRUN_COUNT_EN, underrun_count SHALL be constant 0, no counter logic exists, and the underrun pulse is unchanged.

Structure
REQ-029 The shared package (structures.sv) SHALL hold:
  - I2S_FRAME_BITS=64 and I2S_HALF_BITS=32.
  - The enum i2s_tx_state_t {IDLE, RUN, STOP}.
  - The existing SlotMode.
REQ-030 Sub-module slot_i2s_clkgen SHALL generate bck, the bit index, lrck, the falling-edge strobe and the frame-boundary strobe.

Verification (SAMPLE_WIDTH=24, BCK_HALF=2, 256 mclk/frame)
REQ-031 Single DAC2 frame:
  - Stimulus: preload channel0=24'hA5A5A5, channel1=24'h123456, then enable.
  - Response: slot_model DAC channel-0 FIFO receives left=A5A5A5, right=123456.
  - Response: lrck period = 256 mclk; sdata[3:1]=0.
REQ-032 DAC8 continuous:
  - Stimulus: stream 4 frames, channel c = {frame,c}.
  - Response: all four receiver FIFOs get matching pairs in order with no underrun.
REQ-033 Underrun:
  - Stimulus: withhold in_valid for frame 2 of 3.
  - Response: frame 2 is all zeros; exactly one underrun pulse.
  - Response: underrun_count=1 with the macro, 0 without.
REQ-034 Graceful stop:
  - Stimulus: drop enable at bit index 10.
  - Response: frame completes through index 63; oe falls at the boundary; bck, lrck and sdata are 0 afterwards.
REQ-035 Reset mid-frame:
  - Stimulus: assert reset_n=0 at index 40 with hold_full=1.
  - Response: all outputs 0 immediately; in_ready=1 the cycle after release; no stale frame is transmitted.
REQ-036 Mode switch:
  - Stimulus: change DAC8->ADC2 mid-frame.
  - Response: the frame finishes, the block enters IDLE and oe=0.
